// File: rtl/weight_stream_scheduler.sv
// weight_stream_scheduler: streams a contiguous range of conv filters
// from the weight BRAM to the MAC array through a 2-entry skid FIFO.
module weight_stream_scheduler #(
  parameter int DATA_WIDTH   = 16,
  parameter int IN_CHANNELS  = 4,
  parameter int OUT_CHANNELS = 64,
  parameter int KERNEL_SIZE  = 3,
  parameter int ADDR_WIDTH   =
    $clog2(OUT_CHANNELS * IN_CHANNELS * KERNEL_SIZE * KERNEL_SIZE),
  parameter int OC_WIDTH     = $clog2(OUT_CHANNELS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [OC_WIDTH-1:0]   cfg_oc_base,
  input  logic [OC_WIDTH-1:0]   cfg_oc_count,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  w_valid,
  input  logic                  w_ready,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [OC_WIDTH-1:0]   w_oc,
  output logic                  w_kern_last,
  output logic                  w_filt_last,
  output logic                  w_pass_last
);
  localparam int KE   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int FILT = IN_CHANNELS * KE;
  localparam int KW   = (KE > 1) ? $clog2(KE) : 1;
  localparam int FW   = (FILT > 1) ? $clog2(FILT) : 1;

  typedef enum logic [1:0] {
    S_IDLE, S_RUN, S_DRAIN, S_DONE
  } state_t;

  typedef struct packed {
    logic [OC_WIDTH-1:0] oc;
    logic                kern_last;
    logic                filt_last;
    logic                pass_last;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    tag_t                  tag;
  } ent_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, end_q;
  logic [ADDR_WIDTH-1:0] base_addr, last_addr;
  logic [OC_WIDTH-1:0]   oc_q;
  logic [KW-1:0]         kern_q;
  logic [FW-1:0]         filt_q;
  logic [OC_WIDTH:0]     cfg_sum;
  tag_t                  tag_q, issue_tag;
  ent_t                  fifo_q [2];
  ent_t                  head;
  logic                  infl_q, rd_ptr_q, wr_ptr_q, err_q;
  logic [1:0]            occ_q, room;
  logic                  cfg_bad, accept, go;
  logic                  pop, rd_en, drain_end;

  // Start decode, credit check, issue tags and next state.
  always_comb begin
    state_d   = state_q;
    rd_en     = 1'b0;
    cfg_sum   = {1'b0, cfg_oc_base} + {1'b0, cfg_oc_count};
    cfg_bad   = cfg_sum > (OC_WIDTH+1)'(OUT_CHANNELS);
    accept    = (state_q == S_IDLE) && start && !abort;
    go        = accept && !cfg_bad && (cfg_oc_count != '0);
    base_addr = ADDR_WIDTH'(int'(cfg_oc_base) * FILT);
    last_addr = ADDR_WIDTH'(int'(cfg_sum) * FILT - 1);
    pop       = (occ_q != 2'd0) && w_ready;
    // A word leaving this cycle frees its slot for a new read.
    room      = occ_q + {1'b0, infl_q} - {1'b0, pop};
    drain_end = !infl_q &&
                ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop));
    issue_tag.oc        = oc_q;
    issue_tag.kern_last = kern_q == KW'(KE - 1);
    issue_tag.filt_last = filt_q == FW'(FILT - 1);
    issue_tag.pass_last = addr_q == end_q;
    unique case (state_q)
      S_IDLE: begin
        if (go)
          state_d = S_RUN;
        else if (accept && !cfg_bad)
          state_d = S_DONE;
      end
      S_RUN: begin
        rd_en = (room < 2'd2) && !abort;
        if (rd_en && issue_tag.pass_last)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_end)
          state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort)
      state_d = S_IDLE;
  end

  // State, address counters, tag pipeline and skid FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      err_q    <= 1'b0;
      addr_q   <= '0;
      end_q    <= '0;
      oc_q     <= '0;
      kern_q   <= '0;
      filt_q   <= '0;
      tag_q    <= '0;
      infl_q   <= 1'b0;
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= accept && cfg_bad;
      if (go) begin
        addr_q <= base_addr;
        end_q  <= last_addr;
        oc_q   <= cfg_oc_base;
        kern_q <= '0;
        filt_q <= '0;
      end else if (rd_en) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        kern_q <= issue_tag.kern_last ? '0 : kern_q + KW'(1);
        filt_q <= issue_tag.filt_last ? '0 : filt_q + FW'(1);
        if (issue_tag.filt_last)
          oc_q <= oc_q + OC_WIDTH'(1);
      end
      if (abort) begin
        infl_q   <= 1'b0;
        occ_q    <= '0;
        rd_ptr_q <= 1'b0;
        wr_ptr_q <= 1'b0;
      end else begin
        infl_q <= rd_en;
        if (rd_en)
          tag_q <= issue_tag;
        if (infl_q) begin
          fifo_q[wr_ptr_q] <= '{data: mem_rd_data, tag: tag_q};
          wr_ptr_q <= ~wr_ptr_q;
        end
        if (pop)
          rd_ptr_q <= ~rd_ptr_q;
        occ_q <= occ_q + {1'b0, infl_q} - {1'b0, pop};
      end
    end
  end

  assign head        = fifo_q[rd_ptr_q];
  assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done        = state_q == S_DONE;
  assign cfg_err     = err_q;
  assign mem_rd_en   = rd_en;
  assign mem_addr    = addr_q;
  assign w_valid     = occ_q != 2'd0;
  assign w_data      = head.data;
  assign w_oc        = head.tag.oc;
  assign w_kern_last = head.tag.kern_last;
  assign w_filt_last = head.tag.filt_last;
  assign w_pass_last = head.tag.pass_last;

endmodule

// File: tb/tb_weight_stream_scheduler.sv
// tb_weight_stream_scheduler: random-data scoreboard bench for the
// weight stream scheduler with a registered BRAM model.
module tb_weight_stream_scheduler;
  localparam int DW    = 16;
  localparam int IC    = 4;
  localparam int OCN   = 64;
  localparam int KS    = 3;
  localparam int KE    = KS * KS;
  localparam int FILT  = IC * KE;
  localparam int AW    = 12;
  localparam int OW    = 7;
  localparam int DEPTH = OCN * FILT;

  logic          clk = 1'b0;
  logic          rst, start, abort, w_ready;
  logic [OW-1:0] cfg_oc_base, cfg_oc_count;
  logic          busy, done, cfg_err, mem_rd_en, w_valid;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rd_data, w_data;
  logic [OW-1:0] w_oc;
  logic          w_kern_last, w_filt_last, w_pass_last;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [OW-1:0] oc;
    logic          kl;
    logic          fl;
    logic          pl;
  } word_t;

  word_t         exp_q [$];
  logic [DW-1:0] mem [DEPTH];
  int vectors = 0;
  int miscompares = 0;
  int n_issued = 0;
  int n_acc = 0;
  int ready_mode = 0;

  weight_stream_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_oc_base(cfg_oc_base), .cfg_oc_count(cfg_oc_count),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_oc(w_oc), .w_kern_last(w_kern_last),
    .w_filt_last(w_filt_last), .w_pass_last(w_pass_last)
  );

  always #5 clk = ~clk;

  // Registered BRAM: data appears one cycle after the read strobe.
  always @(posedge clk)
    if (mem_rd_en) mem_rd_data <= mem[mem_addr];

  task automatic chk(string name, longint act, longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: every word of every filter, oc-major, in order.
  task automatic expect_pass(int base, int count);
    for (int oc = base; oc < base + count; oc++)
      for (int ic = 0; ic < IC; ic++)
        for (int k = 0; k < KE; k++) begin
          int a = oc * FILT + ic * KE + k;
          word_t w;
          w.d  = mem[a];
          w.oc = OW'(oc);
          w.kl = (k == KE - 1);
          w.fl = (k == KE - 1) && (ic == IC - 1);
          w.pl = w.fl && (oc == base + count - 1);
          exp_q.push_back(w);
        end
  endtask

  task automatic do_start(int base, int count);
    n_issued = 0;
    n_acc = 0;
    @(posedge clk); #1;
    cfg_oc_base  = OW'(base);
    cfg_oc_count = OW'(count);
    start = 1'b1;
    if (count != 0 && base + count <= OCN)
      expect_pass(base, count);
    @(posedge clk); #1;
    start = 1'b0;
    cfg_oc_base  = OW'($urandom);
    cfg_oc_count = OW'($urandom);
  endtask

  task automatic wait_done(string name, int budget);
    int  c = 0;
    bit  seen = 0;
    while (!seen && c < budget) begin
      @(negedge clk);
      c++;
      if (done) seen = 1;
    end
    chk(name, seen, 1);
  endtask

  task automatic chk_idle(string t);
    chk({t, "_busy"}, busy, 0);
    chk({t, "_done"}, done, 0);
    chk({t, "_cfg_err"}, cfg_err, 0);
    chk({t, "_rd_en"}, mem_rd_en, 0);
    chk({t, "_addr"}, mem_addr, 0);
    chk({t, "_valid"}, w_valid, 0);
    chk({t, "_data"}, w_data, 0);
    chk({t, "_oc"}, w_oc, 0);
    chk({t, "_flags"}, {w_kern_last, w_filt_last, w_pass_last}, 0);
  endtask

  // Consumer ready pattern, updated just after each rising edge.
  initial begin
    w_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: w_ready = 1'b1;
        1: w_ready = 1'($urandom_range(0, 1));
        default: w_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks hold rule.
  initial begin
    word_t got, held_w, e;
    bit    held = 0;
    forever begin
      @(negedge clk);
      got = '{w_data, w_oc, w_kern_last, w_filt_last, w_pass_last};
      if (held) begin
        chk("hold_valid", w_valid, 1);
        chk("hold_stable", got, held_w);
      end
      if (mem_rd_en && !rst && !abort) n_issued++;
      if (w_valid && w_ready && !rst) begin
        n_acc++;
        chk("word_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("word", got, e);
        end
      end
      held   = w_valid && !w_ready && !abort && !rst;
      held_w = got;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int first, nval, done_k, ndone, nerr, nrd, nbusy, gaps, c;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    cfg_oc_base = '0;
    cfg_oc_count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    // base 0, one filter, ready always high
    ready_mode = 0;
    do_start(0, 1);
    first = -1; nval = 0; done_k = -1; ndone = 0;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (w_valid && first < 0) first = k;
      if (w_valid && k >= 2 && k <= 37) nval++;
      if (done) begin
        ndone++;
        if (done_k < 0) done_k = k;
        chk("t1_busy_at_done", busy, 0);
      end
    end
    chk("t1_first_valid", first, 2);
    chk("t1_no_bubble", nval, 36);
    chk("t1_done_cycle", done_k, 38);
    chk("t1_done_count", ndone, 1);
    chk("t1_q_empty", exp_q.size(), 0);

    // top two filters, random backpressure
    ready_mode = 1;
    do_start(62, 2);
    wait_done("t2_done", 2000);
    chk("t2_q_empty", exp_q.size(), 0);
    chk("t2_words", n_acc, 72);

    // ten-cycle stall mid-stream
    ready_mode = 0;
    do_start(10, 1);
    repeat (8) @(posedge clk);
    #3 ready_mode = 2;
    repeat (10) begin
      @(posedge clk); #2;
      chk("t3_outstanding", (n_issued - n_acc) <= 2, 1);
    end
    ready_mode = 0;
    gaps = 0; c = 0;
    do begin
      @(negedge clk);
      c++;
      if (!w_valid && !done) gaps++;
    end while (!done && c < 200);
    chk("t3_done", done, 1);
    chk("t3_gaps", gaps, 0);
    chk("t3_q_empty", exp_q.size(), 0);
    chk("t3_words", n_acc, 36);

    // out-of-range config
    do_start(60, 5);
    nerr = 0; nrd = 0; nbusy = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 0) chk("t4_err_k0", cfg_err, 1);
      nerr += int'(cfg_err);
      nrd += int'(mem_rd_en);
      nbusy += int'(busy);
    end
    chk("t4_err_count", nerr, 1);
    chk("t4_no_reads", nrd, 0);
    chk("t4_no_busy", nbusy, 0);

    // zero-count pass
    do_start(5, 0);
    ndone = 0; nrd = 0; nerr = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("t4z_done_k0", done, 1);
      ndone += int'(done);
      nrd += int'(mem_rd_en);
      nerr += int'(cfg_err);
    end
    chk("t4z_done_count", ndone, 1);
    chk("t4z_no_reads", nrd, 0);
    chk("t4z_no_err", nerr, 0);

    // abort around word 20, then a fresh pass
    ready_mode = 0;
    do_start(7, 3);
    c = 0;
    while (n_acc < 20 && c < 200) begin
      @(posedge clk); #2;
      c++;
    end
    chk("t5_reached_20", n_acc >= 20, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("t5_valid_off", w_valid, 0);
    chk("t5_busy_off", busy, 0);
    exp_q.delete();
    ndone = int'(done);
    repeat (5) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("t5_no_done", ndone, 0);
    do_start(40, 1);
    wait_done("t5_restart_done", 300);
    chk("t5_q_empty", exp_q.size(), 0);
    chk("t5_words", n_acc, 36);

    // start while busy is ignored
    ready_mode = 1;
    do_start(0, 2);
    repeat (15) @(posedge clk);
    #2;
    cfg_oc_base  = OW'(50);
    cfg_oc_count = OW'(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("t6_still_busy", busy, 1);
    wait_done("t6_done", 2000);
    chk("t6_q_empty", exp_q.size(), 0);
    chk("t6_words", n_acc, 72);

    // reset mid-pass, then a fresh pass
    ready_mode = 0;
    do_start(20, 2);
    repeat (30) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle("t7_rst");
    exp_q.delete();
    do_start(63, 1);
    wait_done("t7_done", 300);
    chk("t7_q_empty", exp_q.size(), 0);
    chk("t7_words", n_acc, 36);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
